// File: rtl/spi_slave_if_if.sv
// spi_slave_if_if: byte handshake and SPI pin bundle for spi_slave_if
interface spi_slave_if_if;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       spi_clk;
  logic       spi_miso;
  logic       spi_mosi;
  logic       spi_cs_n;
  modport slave (
    output rx_dv, rx_byte, spi_miso,
    input  tx_dv, tx_byte, spi_clk, spi_mosi, spi_cs_n
  );
  modport master (
    input  rx_dv, rx_byte, spi_miso,
    output tx_dv, tx_byte, spi_clk, spi_mosi, spi_cs_n
  );
endinterface

// File: rtl/spi_slave_if.sv
// spi_slave_if: oversampled SPI slave byte shifter; SPI_SLAVE_MISO_TRISTATE_EN floats MISO while deselected
module spi_slave_if #(
  parameter int SPI_MODE = 0
) (
  input logic           clk,
  input logic           reset_n,
  spi_slave_if_if.slave bus
);
  localparam logic [1:0] MODE = 2'(SPI_MODE);
  localparam logic CPOL = MODE[1];
  localparam logic CPHA = MODE[0];
  logic sck_s1, sck_s2, sck_d, mosi_s1, mosi_s2, cs_s1, cs_s2, cs_d;
  logic [1:0] warm;
  logic armed, byte_done, miso_q, rx_dv_q;
  logic [2:0] cnt;
  logic [7:0] rx_sr, rx_byte_q, tx_hold, tx_sr;
  logic rise, fall, sample_edge, shift_edge, active, cs_fall;
  assign rise        = sck_s2 & ~sck_d;
  assign fall        = ~sck_s2 & sck_d;
  assign sample_edge = (CPOL == CPHA) ? rise : fall;
  assign shift_edge  = (CPOL == CPHA) ? fall : rise;
  // armed only once CS has truly been seen high, so a frame caught mid-flight by reset is ignored
  assign active      = armed & ~cs_s2;
  assign cs_fall     = cs_d & ~cs_s2;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_s1    <= CPOL;
      sck_s2    <= CPOL;
      sck_d     <= CPOL;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      cs_s1     <= 1'b1;
      cs_s2     <= 1'b1;
      cs_d      <= 1'b1;
      warm      <= 2'b00;
      armed     <= 1'b0;
      byte_done <= 1'b0;
      rx_dv_q   <= 1'b0;
      cnt       <= 3'd0;
      rx_sr     <= 8'h00;
      rx_byte_q <= 8'h00;
      tx_hold   <= 8'h00;
      tx_sr     <= 8'h00;
      miso_q    <= 1'b0;
    end else begin
      sck_s1    <= bus.spi_clk;
      sck_s2    <= sck_s1;
      sck_d     <= sck_s2;
      mosi_s1   <= bus.spi_mosi;
      mosi_s2   <= mosi_s1;
      cs_s1     <= bus.spi_cs_n;
      cs_s2     <= cs_s1;
      cs_d      <= cs_s2;
      warm      <= {warm[0], 1'b1};
      armed     <= armed | (warm[1] & cs_s2);
      rx_dv_q   <= byte_done;
      byte_done <= 1'b0;
      if (byte_done) rx_byte_q <= rx_sr;
      if (bus.tx_dv) tx_hold <= bus.tx_byte;
      if (!active) cnt <= 3'd0;
      else begin
        if (sample_edge) begin
          rx_sr     <= {rx_sr[6:0], mosi_s2};
          cnt       <= cnt + 3'd1;
          byte_done <= (cnt == 3'd7);
          if (cnt == 3'd7) tx_sr <= tx_hold;
        end
        if (shift_edge) begin
          miso_q <= tx_sr[7];
          tx_sr  <= {tx_sr[6:0], 1'b0};
        end
      end
      // CPHA=0 presents bit7 straight away, so the shift register keeps only the remaining bits
      if (cs_fall) begin
        miso_q <= tx_hold[7];
        tx_sr  <= CPHA ? tx_hold : {tx_hold[6:0], 1'b0};
      end
    end
  end
  assign bus.rx_dv   = rx_dv_q;
  assign bus.rx_byte = rx_byte_q;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign bus.spi_miso = cs_s2 ? 1'bz : miso_q;
`else
  assign bus.spi_miso = cs_s2 ? 1'b0 : miso_q;
`endif
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: mode 0 and mode 1 slaves on shared SPI pins, table-driven with rx scoreboards
module tb_spi_slave_if;
  logic clk = 1'b0, reset_n = 1'b0, sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1, tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic [7:0] r0, r1;
  logic [7:0] q0[$], q1[$];
  int checks = 0, fails = 0;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  localparam logic IDLE = 1'bz;
`else
  localparam logic IDLE = 1'b0;
`endif
  always #50 clk = ~clk;
  spi_slave_if_if m0();
  spi_slave_if_if m1();
  assign m0.spi_clk  = sclk;
  assign m1.spi_clk  = sclk;
  assign m0.spi_mosi = mosi;
  assign m1.spi_mosi = mosi;
  assign m0.spi_cs_n = cs_n;
  assign m1.spi_cs_n = cs_n;
  assign m0.tx_dv    = tx_dv;
  assign m1.tx_dv    = tx_dv;
  assign m0.tx_byte  = tx_byte;
  assign m1.tx_byte  = tx_byte;
  spi_slave_if #(.SPI_MODE(0)) u_m0 (.clk(clk), .reset_n(reset_n), .bus(m0));
  spi_slave_if #(.SPI_MODE(1)) u_m1 (.clk(clk), .reset_n(reset_n), .bus(m1));
  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    logic [7:0] exp_tx;
    logic       dv;
    logic       last;
    int         nbits;
  } vec_t;
  vec_t vt[8];
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  // mode 0 master reads MISO just before rising edges, mode 1 just before falling edges
  task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] o0, output logic [7:0] o1);
    o0 = 8'h00;
    o1 = 8'h00;
    for (int i = 7; i >= 8 - n; i--) begin
      mosi = b[i];
      tick(1);
      o0 = {o0[6:0], m0.spi_miso};
      sclk = 1'b1;
      tick(3);
      o1 = {o1[6:0], m1.spi_miso};
      sclk = 1'b0;
      tick(2);
    end
  endtask
  task automatic begin_frame(input logic dv, input logic [7:0] tx);
    tx_dv = dv;
    tx_byte = tx;
    tick(2);
    cs_n = 1'b0;
    tick(4);
  endtask
  task automatic end_frame();
    cs_n = 1'b1;
    tick(4);
    chk("m0_miso_idle", {7'd0, m0.spi_miso}, {7'd0, IDLE});
    chk("m1_miso_idle", {7'd0, m1.spi_miso}, {7'd0, IDLE});
  endtask
  always @(negedge clk) begin
    if (reset_n && m0.rx_dv) begin
      if (q0.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL m0_extra_rx_dv: got rx_byte %h expected no pulse", m0.rx_byte);
      end else chk("m0_rx_byte", m0.rx_byte, q0.pop_front());
    end
    if (reset_n && m1.rx_dv) begin
      if (q1.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL m1_extra_rx_dv: got rx_byte %h expected no pulse", m1.rx_byte);
      end else chk("m1_rx_byte", m1.rx_byte, q1.pop_front());
    end
  end
  initial begin
    logic infr;
    vt[0] = '{8'hC1, 8'hA5, 8'hA5, 1'b1, 1'b1, 8};
    vt[1] = '{8'hC1, 8'h3C, 8'h3C, 1'b1, 1'b0, 8};
    vt[2] = '{8'hC2, 8'h3C, 8'h3C, 1'b1, 1'b0, 8};
    vt[3] = '{8'hC3, 8'h3C, 8'h3C, 1'b1, 1'b1, 8};
    vt[4] = '{8'hFF, 8'h96, 8'h00, 1'b1, 1'b1, 5};
    vt[5] = '{8'h5A, 8'h0F, 8'h96, 1'b0, 1'b1, 8};
    vt[6] = '{8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0, 8};
    vt[7] = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 8};
    tick(3);
    chk("m0_reset_rx_dv", {7'd0, m0.rx_dv}, 8'h00);
    chk("m1_reset_rx_dv", {7'd0, m1.rx_dv}, 8'h00);
    chk("m0_reset_rx_byte", m0.rx_byte, 8'h00);
    chk("m1_reset_rx_byte", m1.rx_byte, 8'h00);
    chk("m0_reset_miso", {7'd0, m0.spi_miso}, {7'd0, IDLE});
    chk("m1_reset_miso", {7'd0, m1.spi_miso}, {7'd0, IDLE});
    reset_n = 1'b1;
    tick(6);
    infr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!infr) begin_frame(vt[k].dv, vt[k].tx);
      infr = !vt[k].last;
      if (vt[k].nbits == 8) begin
        q0.push_back(vt[k].rx);
        q1.push_back(vt[k].rx);
      end
      send_bits(vt[k].rx, vt[k].nbits, r0, r1);
      if (vt[k].nbits == 8) begin
        chk($sformatf("m0_miso_vec%0d", k), r0, vt[k].exp_tx);
        chk($sformatf("m1_miso_vec%0d", k), r1, vt[k].exp_tx);
      end
      if (vt[k].last) end_frame();
    end
    chk("m0_rx_byte_hold", m0.rx_byte, 8'hFF);
    chk("m1_rx_byte_hold", m1.rx_byte, 8'hFF);
    // reset mid-byte: the rest of that frame must be ignored
    begin_frame(1'b1, 8'h00);
    send_bits(8'hF0, 4, r0, r1);
    #10 reset_n = 1'b0;
    #1;
    chk("m0_midreset_rx_dv", {7'd0, m0.rx_dv}, 8'h00);
    chk("m1_midreset_rx_dv", {7'd0, m1.rx_dv}, 8'h00);
    chk("m0_midreset_rx_byte", m0.rx_byte, 8'h00);
    chk("m1_midreset_rx_byte", m1.rx_byte, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    send_bits(8'h00, 4, r0, r1);
    send_bits(8'h33, 8, r0, r1);
    end_frame();
    begin_frame(1'b1, 8'h00);
    q0.push_back(8'h96);
    q1.push_back(8'h96);
    send_bits(8'h96, 8, r0, r1);
    end_frame();
    // CS rises together with the mode 1 eighth sample edge; mode 0 already sampled on the rise
    begin_frame(1'b1, 8'h00);
    q0.push_back(8'h6B);
    send_bits(8'h6B, 7, r0, r1);
    mosi = 1'b1;
    tick(1);
    sclk = 1'b1;
    tick(3);
    cs_n = 1'b1;
    sclk = 1'b0;
    tick(6);
    begin_frame(1'b1, 8'h00);
    q0.push_back(8'h81);
    q1.push_back(8'h81);
    send_bits(8'h81, 8, r0, r1);
    end_frame();
    tick(10);
    chk("m0_scoreboard_empty", 8'(q0.size()), 8'h00);
    chk("m1_scoreboard_empty", 8'(q1.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
